// File: rtl/mips_ctrl_multiciclo_param.sv
// Multicycle MIPS control unit: Moore FSM for datapath strobes, ALU decoder,
// optional memory wait-state handshake, illegal-opcode flag and retired-instruction counter.
module mips_ctrl_multiciclo_param #(
  parameter int unsigned STATE_W = 5,
  parameter int unsigned EXT_ISA = 1,
  parameter int unsigned MEM_HS  = 0,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clock,
  input  logic               resete,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               mem_ready,
  output logic [STATE_W-1:0] estado,
  output logic               IorD,
  output logic               AluSrcA,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               Branch,
  output logic               BranchNe,
  output logic [1:0]         AluSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         PCSrc,
  output logic [2:0]         ALUControl,
  output logic               illegal_op,
  output logic [CNT_W-1:0]   instr_count
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BNE  = 6'b000101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam bit EXT = (EXT_ISA != 0);
  localparam bit HS  = (MEM_HS != 0);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = STATE_W'(0),
    S_DECODE = STATE_W'(1),
    S_MEMADR = STATE_W'(2),
    S_MEMRD  = STATE_W'(3),
    S_MEMWB  = STATE_W'(4),
    S_MEMWR  = STATE_W'(5),
    S_EXEC   = STATE_W'(6),
    S_ALUWB  = STATE_W'(7),
    S_BEQ    = STATE_W'(8),
    S_ADDIEX = STATE_W'(9),
    S_ADDIWB = STATE_W'(10),
    S_JUMP   = STATE_W'(11),
    S_BNE    = STATE_W'(12)
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready;
  logic             funct_ok;
  logic             retire;

  always_ff @(posedge clock or negedge resete) begin
    if (!resete) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign estado      = state_q;
  assign instr_count = cnt_q;

  // Next state and Moore strobes; only FETCH/MEMRD/MEMWR look at mem_ready.
  always_comb begin
    state_d    = S_FETCH;
    IorD       = 1'b0;
    AluSrcA    = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    Branch     = 1'b0;
    BranchNe   = 1'b0;
    AluSrcB    = 2'b00;
    ALUOp      = 2'b00;
    PCSrc      = 2'b00;
    illegal_op = 1'b0;
    ready      = !HS || mem_ready;
    funct_ok   = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                 (funct == FN_OR)  || (funct == FN_SLT);
    case (state_q)
      S_FETCH: begin
        AluSrcB = 2'b01;
        IRWrite = ready;
        PCWrite = ready;
        state_d = ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        AluSrcB = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:    if (funct_ok) state_d = S_EXEC;   else illegal_op = 1'b1;
          OP_BEQ:  state_d = S_BEQ;
          OP_ADDI: if (EXT) state_d = S_ADDIEX;      else illegal_op = 1'b1;
          OP_J:    if (EXT) state_d = S_JUMP;        else illegal_op = 1'b1;
          OP_BNE:  if (EXT) state_d = S_BNE;         else illegal_op = 1'b1;
          default: illegal_op = 1'b1;
        endcase
      end
      S_MEMADR: begin
        AluSrcA = 1'b1;
        AluSrcB = 2'b10;
        state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        state_d = ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        state_d  = ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        AluSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BEQ: begin
        AluSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 2'b01;
        Branch  = 1'b1;
      end
      S_ADDIEX: begin
        AluSrcA = 1'b1;
        AluSrcB = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_JUMP: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
      end
      S_BNE: begin
        AluSrcA  = 1'b1;
        ALUOp    = 2'b01;
        PCSrc    = 2'b01;
        BranchNe = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    // Only completed instructions retire; the illegal-op path back to FETCH does not.
    retire = (state_d == S_FETCH) &&
             (state_q inside {S_MEMWB, S_MEMWR, S_ALUWB, S_BEQ, S_BNE, S_ADDIWB, S_JUMP});
    cnt_d  = cnt_q + (retire ? CNT_W'(1) : CNT_W'(0));
  end

  // ALU decoder.
  always_comb begin
    ALUControl = 3'b010;
    case (ALUOp)
      2'b01: ALUControl = 3'b110;
      2'b10: begin
        case (funct)
          FN_SUB:  ALUControl = 3'b110;
          FN_AND:  ALUControl = 3'b000;
          FN_OR:   ALUControl = 3'b001;
          FN_SLT:  ALUControl = 3'b111;
          default: ALUControl = 3'b010;
        endcase
      end
      default: ALUControl = 3'b010;
    endcase
  end

endmodule
